// File: rtl/sd_cmd_phy.sv
// SD CMD-line serial engine: sends a 48-bit command with its CRC7, then
// optionally captures and checks a 48-bit response within an NCR timeout.
module sd_cmd_phy #(
    parameter int TIMEOUT = 64,
    parameter int NCC     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [5:0]  idx_i,
    input  logic [31:0] arg_i,
    input  logic        resp_en_i,
    input  logic        crc_chk_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [5:0]  resp_idx_o,
    output logic [31:0] resp_o,
    output logic        timeout_o,
    output logic        crc_err_o,
    input  logic        cmd_i,
    output logic        cmd_o,
    output logic        cmd_oe_o
);

    localparam int CNT_MAX = ((TIMEOUT + 1) > 48) ?
                             (((TIMEOUT + 1) > NCC) ? (TIMEOUT + 1) : NCC) :
                             ((NCC > 48) ? NCC : 48);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_CRC_END = CNT_W'(40);
    localparam logic [CNT_W-1:0] CNT_TX_LAST = CNT_W'(48);
    localparam logic [CNT_W-1:0] CNT_RX_CRC  = CNT_W'(39);
    localparam logic [CNT_W-1:0] CNT_RX_LAST = CNT_W'(47);
    localparam logic [CNT_W-1:0] CNT_TMO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_GAP     = CNT_W'(NCC);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [46:0]      tx_sr_q, tx_sr_d;
    logic [46:0]      rx_sr_q, rx_sr_d;
    logic [6:0]       crc_q, crc_d;
    logic             resp_en_q, resp_en_d;
    logic             crc_chk_q, crc_chk_d;
    logic             cmd_o_q, cmd_o_d;
    logic             cmd_oe_q, cmd_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [5:0]       resp_idx_q, resp_idx_d;
    logic [31:0]      resp_q, resp_d;
    logic             timeout_q, timeout_d;
    logic             crc_err_q, crc_err_d;
    logic [6:0]       crc_tx_s;
    logic [6:0]       crc_rx_s;

    assign crc_tx_s = crc7_step(crc_q, cmd_o_q);
    assign crc_rx_s = crc7_step(crc_q, cmd_i);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_SEND;
                else         state_d = ST_IDLE;
            end
            ST_SEND: begin
                if (cnt_q == CNT_TX_LAST) state_d = resp_en_q ? ST_WAIT : ST_GAP;
                else                      state_d = ST_SEND;
            end
            ST_WAIT: begin
                // timeout_q set means the one-cycle flag-visible slot has elapsed
                if (timeout_q)   state_d = ST_GAP;
                else if (!cmd_i) state_d = ST_RECV;
                else             state_d = ST_WAIT;
            end
            ST_RECV: begin
                if (cnt_q == CNT_RX_LAST) state_d = ST_GAP;
                else                      state_d = ST_RECV;
            end
            ST_GAP: begin
                if (cnt_q == CNT_GAP) state_d = ST_DONE;
                else                  state_d = ST_GAP;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops line up with it
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        cmd_oe_d = (state_d == ST_SEND);
    end

    // Datapath next-state: counters, shifters, CRC and status
    always_comb begin
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        crc_d      = crc_q;
        resp_en_d  = resp_en_q;
        crc_chk_d  = crc_chk_q;
        cmd_o_d    = 1'b1;
        resp_idx_d = resp_idx_q;
        resp_d     = resp_q;
        timeout_d  = timeout_q;
        crc_err_d  = crc_err_q;

        if (state_d == ST_IDLE)      cnt_d = {CNT_W{1'b0}};
        else if (state_d != state_q) cnt_d = CNT_ONE;
        else                         cnt_d = cnt_q + CNT_ONE;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    resp_en_d  = resp_en_i;
                    crc_chk_d  = crc_chk_i;
                    cmd_o_d    = 1'b0;
                    tx_sr_d    = {1'b1, idx_i, arg_i, 7'h00, 1'b1};
                    crc_d      = 7'h00;
                    resp_idx_d = 6'h00;
                    resp_d     = 32'h0000_0000;
                    timeout_d  = 1'b0;
                    crc_err_d  = 1'b0;
                end else begin
                    cmd_o_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (cnt_q <= CNT_CRC_END) crc_d = crc_tx_s;
                else                      crc_d = crc_q;
                // Once the 40th bit is out, the CRC bits take over the reserved slots
                if (cnt_q == CNT_CRC_END) begin
                    cmd_o_d = crc_tx_s[6];
                    tx_sr_d = {crc_tx_s[5:0], 1'b1, 40'h00_0000_0000};
                end else if (cnt_q < CNT_TX_LAST) begin
                    cmd_o_d = tx_sr_q[46];
                    tx_sr_d = {tx_sr_q[45:0], 1'b0};
                end else begin
                    cmd_o_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!timeout_q && !cmd_i) begin
                    crc_d = 7'h00;
                end else if (!timeout_q && (cnt_q == CNT_TMO)) begin
                    timeout_d = 1'b1;
                end else begin
                    crc_d = crc_q;
                end
            end
            ST_RECV: begin
                rx_sr_d = {rx_sr_q[45:0], cmd_i};
                if (cnt_q <= CNT_RX_CRC) crc_d = crc_rx_s;
                else                     crc_d = crc_q;
                if (cnt_q == CNT_RX_LAST) begin
                    resp_idx_d = rx_sr_d[45:40];
                    resp_d     = rx_sr_d[39:8];
                    crc_err_d  = (crc_chk_q && (crc_q != rx_sr_d[7:1])) || !cmd_i;
                end else begin
                    crc_err_d  = crc_err_q;
                end
            end
            ST_GAP:  cmd_o_d = 1'b1;
            ST_DONE: cmd_o_d = 1'b1;
            default: cmd_o_d = 1'b1;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            tx_sr_q    <= 47'h0;
            rx_sr_q    <= 47'h0;
            crc_q      <= 7'h00;
            resp_en_q  <= 1'b0;
            crc_chk_q  <= 1'b0;
            cmd_o_q    <= 1'b1;
            cmd_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            resp_idx_q <= 6'h00;
            resp_q     <= 32'h0000_0000;
            timeout_q  <= 1'b0;
            crc_err_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            crc_q      <= crc_d;
            resp_en_q  <= resp_en_d;
            crc_chk_q  <= crc_chk_d;
            cmd_o_q    <= cmd_o_d;
            cmd_oe_q   <= cmd_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            resp_idx_q <= resp_idx_d;
            resp_q     <= resp_d;
            timeout_q  <= timeout_d;
            crc_err_q  <= crc_err_d;
        end
    end

    assign cmd_o      = cmd_o_q;
    assign cmd_oe_o   = cmd_oe_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign resp_idx_o = resp_idx_q;
    assign resp_o     = resp_q;
    assign timeout_o  = timeout_q;
    assign crc_err_o  = crc_err_q;

endmodule

// File: doc/sd_cmd_phy.md
# sd_cmd_phy

Serial engine for the SD CMD line, clocked by the SD card clock produced by the SD PLL (≈398 kHz during identification, ≈50 MHz in transfer mode). Serialises a 48-bit command frame with its CRC7, releases the line, and captures and checks an optional 48-bit response with an NCR timeout. It sits between the PLL and the SD host controller FSM, which issues one command at a time via a start/done handshake.

## Interface
- `TIMEOUT`, 64: maximum clk cycles to wait for a response start bit after the line is released.
- `NCC`, 8: idle clk cycles inserted after each transaction before `done_o`.
- `clk` in 1: SD clock from PLL; top level drives SD_CLK = ~clk, so the card samples mid-bit.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_i` in 1: request a command; sampled only in IDLE.
- `idx_i` in 6: command index.
- `arg_i` in 32: command argument.
- `resp_en_i` in 1: 1 = expect a 48-bit response, 0 = no response.
- `crc_chk_i` in 1: 1 = check response CRC7 (0 for R3).
- `busy_o` out 1: transaction in progress.
- `done_o` out 1: one-cycle completion pulse.
- `resp_idx_o` out 6: response bits [45:40].
- `resp_o` out 32: response bits [39:8].
- `timeout_o` out 1: no start bit within TIMEOUT.
- `crc_err_o` out 1: CRC7 mismatch or end bit not 1.
- `cmd_i` in 1: CMD line input (pulled up externally).
- `cmd_o` out 1: CMD line drive value.
- `cmd_oe_o` out 1: CMD line output enable.

## Operation
- States: IDLE, SEND, WAIT, RECV, GAP, DONE.
- IDLE: `start_i`=1 latches `idx_i`, `arg_i`, `resp_en_i`, `crc_chk_i`; clears `resp_o`, `resp_idx_o`, `timeout_o`, `crc_err_o`; goes to SEND.
- SEND: drive frame MSB first: `0`, `1`, idx[5:0], arg[31:0], CRC7[6:0], `1`. CRC7 uses polynomial x^7+x^3+1, init 0, over the first 40 bits, and is computed serially while shifting. After bit 48: go to WAIT if `resp_en`, else GAP.
- WAIT: `cmd_oe_o`=0. Sample `cmd_i` each cycle. First 0 is the start bit: go to RECV. After TIMEOUT cycles with no 0: set `timeout_o`, go to GAP.
- RECV: shift in the remaining 47 bits. The CRC7 runs over the start bit plus the next 39 bits (40 total) and is compared with received bits [7:1]. Set `crc_err_o` if (`crc_chk` and mismatch) or end bit is 0. The transmission bit is not checked. Then go to GAP.
- GAP: NCC cycles with `cmd_oe_o`=0, then DONE.
- DONE: `done_o`=1 for one cycle, return to IDLE.
- `start_i` outside IDLE is ignored (no queueing).
- Status outputs hold their values from DONE until the next accepted start.

## Timing
- Reset values (asynchronous, any state including mid-frame): state IDLE, `cmd_oe_o`=0, `cmd_o`=1, `busy_o`=0, `done_o`=0, `resp_o`=0, `resp_idx_o`=0, `timeout_o`=0, `crc_err_o`=0.
- Cycle 0: `start_i` sampled high in IDLE.
- Cycles 1..48: `cmd_oe_o`=1, bit k on `cmd_o`. `busy_o`=1 from cycle 1 through the DONE cycle inclusive.
- No response: cycles 49..48+NCC in GAP; `done_o` at cycle 49+NCC (57 with defaults).
- Response: WAIT starts at cycle 49. A start bit sampled at WAIT cycle w (1..TIMEOUT) puts the end bit at cycle 48+w+47. `done_o` follows NCC+1 cycles later.
- Timeout: `timeout_o` rises at cycle 48+TIMEOUT+1; `done_o` at cycle 48+TIMEOUT+NCC+2.
- A start bit sampled exactly on WAIT cycle TIMEOUT is accepted, not a timeout.
- Results are valid in the `done_o` cycle.
- Back-to-back: `start_i` held high is accepted on the cycle after DONE.

## Test plan
- CMD0, arg 0x00000000, `resp_en_i`=0 -> `cmd_o` serialises 0x400000000095; `done_o` at cycle 57; all flags 0.
- CMD8, arg 0x000001AA, card model replies 0x08000001AA13 after 5 cycles -> transmitted frame 0x48000001AA87; `resp_idx_o`=8, `resp_o`=0x000001AA, `crc_err_o`=0.
- Same as the CMD8 case with one CRC bit of the reply flipped -> `crc_err_o`=1. With `crc_chk_i`=0 -> `crc_err_o`=0. End bit forced to 0 -> `crc_err_o`=1 regardless of `crc_chk_i`.
- CMD55, `resp_en_i`=1, `cmd_i` held 1 -> `timeout_o`=1, `done_o` at cycle 122. Start bit on WAIT cycle 64 -> accepted, `timeout_o`=0.
- `rst_n` pulsed low mid-SEND and mid-RECV -> outputs take reset values immediately; the next `start_i` produces a correct full frame.
- `start_i` pulsed during SEND -> ignored; exactly one frame and one `done_o`.
